spart_rx: RTL and testbench
===========================

Name: spart_rx

Overview:
- Parametrised SPART receive engine. It is the next-generation replacement for the fixed 8N1 receiver inside lab1_spart.
- It oversamples the synchronised GPIO rxd line against a programmable baud divisor and deframes start/data/stop bits, LSB first.
- Received words are buffered in a small FIFO, which the bus-interface/display logic drains with a read strobe.
- It reports framing and overrun errors and has generic data width, oversample ratio and FIFO depth.

Parameters:
- DATA_BITS, 8, data bits per frame (5..9).
- OVERSAMPLE, 16, baud ticks per bit period (even, >= 4).
- DIV_W, 16, width of the divisor input.
- FIFO_DEPTH, 4, receive FIFO entries (power of two, >= 2).

Ports:
- clk  in  1  system clock (50 MHz on board).
- rst  in  1  asynchronous, active-high reset.
- rxd  in  1  raw serial input, idle high, asynchronous to clk.
- divisor  in  DIV_W  clk cycles per baud tick; a value of 0 is treated as 1.
- rd_en  in  1  pop strobe for the head of the FIFO; ignored when empty.
- rx_data  out  DATA_BITS  head of FIFO; valid while rx_valid is high.
- rx_valid  out  1  FIFO not empty.
- fifo_full  out  1  FIFO holds FIFO_DEPTH entries.
- overrun  out  1  sticky; set when a good frame arrives while the FIFO is full; cleared by rd_en.
- framing_err  out  1  one-cycle pulse when the stop bit is sampled low.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: rx_data 0, rx_valid 0, fifo_full 0, overrun 0, framing_err 0, busy 0. FSM in IDLE, FIFO empty, synchroniser flops preset to 1.
- Synchroniser: rxd passes through two flops to give rxd_s. All decisions use rxd_s, so there is 2 clk of input latency.
- Tick generator: a down-counter reloads to divisor-1 and asserts tick for one clk when it reaches 0.
  - It free-runs in IDLE and restarts on the falling edge that enters START, so the phase aligns to the start edge.
  - A divisor change takes effect on the next reload.
- FSM states: IDLE, START, DATA, STOP, WAIT_IDLE. A tick counter (log2 OVERSAMPLE bits) and a bit counter run alongside.
  - IDLE: rxd_s == 0 -> START, tick count cleared.
  - START: after OVERSAMPLE/2 ticks (mid-bit), sample rxd_s. If 1 it is a false start -> IDLE with nothing logged. If 0 -> DATA.
  - DATA: every OVERSAMPLE ticks, shift rxd_s into the MSB of the shift register (LSB first on the wire). After DATA_BITS samples -> STOP, or -> PARITY if the optional feature is built in.
  - STOP: after OVERSAMPLE ticks, sample rxd_s.
    - 1 with no error: push the word (or set overrun if the FIFO is full), then -> IDLE.
    - 0: pulse framing_err, drop the word, -> WAIT_IDLE.
  - WAIT_IDLE: hold until rxd_s == 1, then -> IDLE. This stops a break condition from retriggering.
- FIFO: circular buffer with read and write pointers and a count of width log2(FIFO_DEPTH)+1. rx_data shows the head combinationally.
  - Push and pop in the same cycle: both take effect and the count is unchanged. This applies when full, so a pop frees the slot and overrun is not set.
  - Push while full without a pop: the new word is dropped, the old contents are kept, and overrun is set.
  - Pointers wrap modulo FIFO_DEPTH.
- Latency: a pushed word appears on rx_data/rx_valid 1 clk after the stop-bit sample.
- Reset mid-frame: the partial word is discarded, the FIFO is emptied, and the FSM returns to IDLE on the next rising clk after rst falls.

Optional Feature:
- Macro: SPART_RX_PARITY_EN.
- Defined:
  - Adds a PARITY state between DATA and STOP that samples one extra bit OVERSAMPLE ticks after the last data bit.
  - Adds input parity_odd (1 bit) and output parity_err, a one-cycle pulse.
  - On parity mismatch: pulse parity_err at the stop-bit sample and drop the word. Framing checks still apply.
- Undefined: the PARITY state, parity_odd and parity_err are absent, and the frame is 1 start + DATA_BITS + 1 stop.

Decomposition:
- Package spart_pkg holds:
  - the rx_state_t enum (IDLE, START, DATA, PARITY, STOP, WAIT_IDLE);
  - the function baud_div(clk_hz, baud, os) that returns the divisor;
  - the constant DEF_OVERSAMPLE = 16.
- One sub-module, spart_fifo, parametrised by WIDTH and DEPTH. It is reused later by spart_tx.

Test Plan:
- divisor=162, OVERSAMPLE 16, 20 ns clk (one bit = 51840 ns). Send frame 0x55 (start 0, bits 1,0,1,0,1,0,1,0, stop 1) -> rx_valid rises about 1 clk after the mid-stop sample, rx_data=0x55, busy returns to 0.
- Glitch rxd low for 20000 ns (less than half a bit) -> no push, FSM back in IDLE, framing_err never pulses.
- Send 0xA3 with the stop bit held 0 for 3 bit times -> one framing_err pulse, FIFO unchanged, busy stays high until rxd returns to 1.
- Send 5 frames 0x01..0x05 with no rd_en and FIFO_DEPTH=4 -> fifo_full=1, overrun=1. Four pops return 0x01..0x04, and overrun clears on the first pop.
- Assert rst during bit 3 of a frame, with 2 words queued -> rx_valid=0 immediately. The next clean frame 0x7E is received correctly.
- SPART_RX_PARITY_EN, parity_odd=0. Send 0x07 with parity bit 1 -> accepted. Send 0x07 with parity bit 0 -> parity_err pulse and no push.

Source files
------------

// File: rtl/spart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spart_pkg
//  Description : Shared types and helpers for the SPART receive/transmit
//                engines: receiver state encoding, baud divisor helper and
//                default oversample ratio.
//  Revision    : 1.0 - initial release
// ============================================================================
package spart_pkg;

    localparam int DEF_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP      = 3'd4,
        WAIT_IDLE = 3'd5
    } rx_state_t;

    // Divisor (clk cycles per baud tick) for a clock, baud rate and oversample ratio.
    // Truncates, so 50 MHz / (19200 * 16) gives 162.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input int unsigned baud,
                                             input int unsigned os);
        if ((baud * os) == 0)
            return 0;
        return clk_hz / (baud * os);
    endfunction

endpackage
`default_nettype wire

// File: rtl/spart_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : spart_fifo
//  Description : Small circular-buffer FIFO with combinational head output.
//                Simultaneous push and pop are both honoured, even when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int c_aw = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wptr;
    logic [c_aw-1:0]  r_rptr;
    logic [c_aw:0]    r_count;
    logic             w_do_rd;
    logic             w_do_wr;

    assign empty   = (r_count == '0);
    assign full    = (r_count == (c_aw+1)'(DEPTH));
    assign w_do_rd = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is legal then.
    assign w_do_wr = wr_en && (!full || w_do_rd);
    assign rd_data = empty ? '0 : r_mem[r_rptr];

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (w_do_wr)
            r_mem[r_wptr] <= wr_data;
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_wr)
                r_wptr <= r_wptr + c_aw'(1);
            if (w_do_rd)
                r_rptr <= r_rptr + c_aw'(1);
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (c_aw+1)'(1);
                2'b01:   r_count <= r_count - (c_aw+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/spart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : spart_rx
//  Description : Parametrised SPART receive engine. Oversampled start/data/
//                stop deframing (LSB first), receive FIFO, framing and
//                overrun reporting.
//                Optional build macro SPART_RX_PARITY_EN adds a parity bit
//                (parity_odd selects odd parity) and a parity_err pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module spart_rx
    import spart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = DEF_OVERSAMPLE,
    parameter int DIV_W      = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic [DIV_W-1:0]     divisor,
    input  logic                 rd_en,
`ifdef SPART_RX_PARITY_EN
    input  logic                 parity_odd,
    output logic                 parity_err,
`endif
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 fifo_full,
    output logic                 overrun,
    output logic                 framing_err,
    output logic                 busy
);
    localparam int c_os_w  = $clog2(OVERSAMPLE);
    localparam int c_bit_w = $clog2(DATA_BITS);
    localparam logic [c_os_w-1:0]  c_os_mid  = c_os_w'(OVERSAMPLE/2 - 1);
    localparam logic [c_os_w-1:0]  c_os_last = c_os_w'(OVERSAMPLE - 1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(DATA_BITS - 1);

    logic [1:0]           r_sync;
    logic                 w_rxd_s;
    logic [DIV_W-1:0]     r_baud_cnt;
    logic [DIV_W-1:0]     w_div_m1;
    logic                 w_tick;
    logic                 w_restart;

    rx_state_t            r_state, w_state_nx;
    logic [c_os_w-1:0]    r_os_cnt, w_os_nx;
    logic [c_bit_w-1:0]   r_bit_cnt, w_bit_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic                 w_push;
    logic                 w_ferr;
    logic                 w_pop;
    logic                 w_empty;
    logic                 r_overrun;
    logic                 r_ferr;
`ifdef SPART_RX_PARITY_EN
    logic                 r_par, w_par_nx;
    logic                 w_par_bad;
    logic                 w_perr;
    logic                 r_perr;
`endif

    // Two-flop synchroniser, preset to the idle level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sync <= 2'b11;
        else
            r_sync <= {r_sync[0], rxd};
    end
    assign w_rxd_s = r_sync[1];

    // Baud tick down-counter; restarted on the start edge so ticks align to it.
    assign w_div_m1  = (divisor == '0) ? '0 : divisor - DIV_W'(1);
    assign w_tick    = (r_baud_cnt == '0);
    assign w_restart = (r_state == IDLE) && !w_rxd_s;

    // Tick counter reload/decrement.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_baud_cnt <= '0;
        else if (w_restart || w_tick)
            r_baud_cnt <= w_div_m1;
        else
            r_baud_cnt <= r_baud_cnt - DIV_W'(1);
    end

`ifdef SPART_RX_PARITY_EN
    // Total ones over data and parity bit must match the selected parity.
    assign w_par_bad = ((^r_shift) ^ r_par) != parity_odd;
`endif

    // Receiver state register and deframing datapath.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_os_cnt  <= '0;
            r_bit_cnt <= '0;
            r_shift   <= '0;
`ifdef SPART_RX_PARITY_EN
            r_par     <= 1'b0;
`endif
        end else begin
            r_state   <= w_state_nx;
            r_os_cnt  <= w_os_nx;
            r_bit_cnt <= w_bit_nx;
            r_shift   <= w_shift_nx;
`ifdef SPART_RX_PARITY_EN
            r_par     <= w_par_nx;
`endif
        end
    end

    // Next-state logic: mid-bit sampling driven by the oversample tick count.
    always_comb begin
        w_state_nx = r_state;
        w_os_nx    = r_os_cnt;
        w_bit_nx   = r_bit_cnt;
        w_shift_nx = r_shift;
        w_push     = 1'b0;
        w_ferr     = 1'b0;
`ifdef SPART_RX_PARITY_EN
        w_par_nx   = r_par;
        w_perr     = 1'b0;
`endif
        case (r_state)
            IDLE: begin
                if (!w_rxd_s) begin
                    w_state_nx = START;
                    w_os_nx    = '0;
                    w_bit_nx   = '0;
                end
            end
            START: begin
                if (w_tick) begin
                    if (r_os_cnt == c_os_mid) begin
                        w_os_nx    = '0;
                        w_state_nx = w_rxd_s ? IDLE : DATA;
                    end else begin
                        w_os_nx = r_os_cnt + c_os_w'(1);
                    end
                end
            end
            DATA: begin
                if (w_tick) begin
                    if (r_os_cnt == c_os_last) begin
                        w_os_nx    = '0;
                        w_shift_nx = {w_rxd_s, r_shift[DATA_BITS-1:1]};
                        w_bit_nx   = r_bit_cnt + c_bit_w'(1);
                        if (r_bit_cnt == c_bit_last) begin
`ifdef SPART_RX_PARITY_EN
                            w_state_nx = PARITY;
`else
                            w_state_nx = STOP;
`endif
                        end
                    end else begin
                        w_os_nx = r_os_cnt + c_os_w'(1);
                    end
                end
            end
`ifdef SPART_RX_PARITY_EN
            PARITY: begin
                if (w_tick) begin
                    if (r_os_cnt == c_os_last) begin
                        w_os_nx    = '0;
                        w_par_nx   = w_rxd_s;
                        w_state_nx = STOP;
                    end else begin
                        w_os_nx = r_os_cnt + c_os_w'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (w_tick) begin
                    if (r_os_cnt == c_os_last) begin
                        w_os_nx = '0;
`ifdef SPART_RX_PARITY_EN
                        w_perr  = w_par_bad;
`endif
                        if (w_rxd_s) begin
`ifdef SPART_RX_PARITY_EN
                            w_push = !w_par_bad;
`else
                            w_push = 1'b1;
`endif
                            w_state_nx = IDLE;
                        end else begin
                            w_ferr     = 1'b1;
                            w_state_nx = WAIT_IDLE;
                        end
                    end else begin
                        w_os_nx = r_os_cnt + c_os_w'(1);
                    end
                end
            end
            WAIT_IDLE: begin
                if (w_rxd_s)
                    w_state_nx = IDLE;
            end
            default: w_state_nx = IDLE;
        endcase
    end

    spart_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (w_push),
        .wr_data (r_shift),
        .rd_en   (rd_en),
        .rd_data (rx_data),
        .empty   (w_empty),
        .full    (fifo_full)
    );

    assign rx_valid = !w_empty;
    assign w_pop    = rd_en && !w_empty;

    // Sticky overrun and single-cycle error pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_overrun <= 1'b0;
            r_ferr    <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            r_perr    <= 1'b0;
`endif
        end else begin
            if (w_push && fifo_full && !w_pop)
                r_overrun <= 1'b1;
            else if (rd_en)
                r_overrun <= 1'b0;
            r_ferr <= w_ferr;
`ifdef SPART_RX_PARITY_EN
            r_perr <= w_perr;
`endif
        end
    end

    assign overrun     = r_overrun;
    assign framing_err = r_ferr;
    assign busy        = (r_state != IDLE);
`ifdef SPART_RX_PARITY_EN
    assign parity_err  = r_perr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_spart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spart_rx
//  Description : Self-checking bench for spart_rx: serialises frames on rxd
//                and compares received words against a queue-based model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spart_rx;
    localparam int c_os    = 16;
    localparam int c_depth = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rxd = 1'b1;
    logic [15:0] divisor = 16'd162;
    logic        rd_en = 1'b0;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        fifo_full;
    logic        overrun;
    logic        framing_err;
    logic        busy;
`ifdef SPART_RX_PARITY_EN
    logic        parity_odd = 1'b0;
    logic        parity_err;
    int          perr_cnt = 0;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int ferr_cnt = 0;

    spart_rx #(
        .DATA_BITS  (8),
        .OVERSAMPLE (c_os),
        .DIV_W      (16),
        .FIFO_DEPTH (c_depth)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rxd         (rxd),
        .divisor     (divisor),
        .rd_en       (rd_en),
`ifdef SPART_RX_PARITY_EN
        .parity_odd  (parity_odd),
        .parity_err  (parity_err),
`endif
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .fifo_full   (fifo_full),
        .overrun     (overrun),
        .framing_err (framing_err),
        .busy        (busy)
    );

    always #10 clk = ~clk;

    // Count error pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (framing_err === 1'b1) ferr_cnt++;
`ifdef SPART_RX_PARITY_EN
        if (parity_err === 1'b1) perr_cnt++;
`endif
    end

    function automatic int bit_clks();
        return c_os * ((divisor == 16'd0) ? 1 : int'(divisor));
    endfunction

    task automatic drive_bit(input logic b, input int ncyc);
        rxd = b;
        repeat (ncyc) @(negedge clk);
    endtask

    // Start bit, data LSB first, optional parity, then stop level for nstop bits.
    task automatic send_frame(input logic [7:0] d, input logic stop_val,
                              input int nstop, input bit par_flip);
        drive_bit(1'b0, bit_clks());
        for (int i = 0; i < 8; i++) drive_bit(d[i], bit_clks());
`ifdef SPART_RX_PARITY_EN
        drive_bit((^d) ^ parity_odd ^ par_flip, bit_clks());
`else
        if (par_flip) ; // no parity bit in this build
`endif
        drive_bit(stop_val, nstop * bit_clks());
        rxd = 1'b1;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if (rx_data !== 8'h00) begin n_fail++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); end
        n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL reset_fifo_full: got %b expected 0", fifo_full); end
        n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun: got %b expected 0", overrun); end
        n_checks++; if (framing_err !== 1'b0) begin n_fail++; $display("FAIL reset_framing_err: got %b expected 0", framing_err); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
        rst = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    // 0x55 at divisor 162; word must not appear before mid-stop but must appear after.
    task automatic test_basic();
        logic [7:0] d = 8'h55;
        int f0 = ferr_cnt;
        divisor = 16'd162;
        drive_bit(1'b0, bit_clks());
        for (int i = 0; i < 8; i++) drive_bit(d[i], bit_clks());
`ifdef SPART_RX_PARITY_EN
        drive_bit((^d) ^ parity_odd, bit_clks());
`endif
        drive_bit(1'b1, bit_clks()/2 - 8);
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b expected 0", rx_valid); end
        drive_bit(1'b1, bit_clks()/2 + 8);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL basic_valid: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== 8'h55) begin n_fail++; $display("FAIL basic_data: got %h expected 55", rx_data); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_busy: got %b expected 0", busy); end
        n_checks++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL basic_ferr: got %0d expected %0d", ferr_cnt, f0); end
        pop();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL basic_pop_empty: got %b expected 0", rx_valid); end
    endtask

    // Low pulse shorter than half a bit must be rejected as a false start.
    task automatic test_glitch();
        int f0 = ferr_cnt;
        divisor = 16'd8;
        drive_bit(1'b1, bit_clks());
        drive_bit(1'b0, 10);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b expected 1", busy); end
        drive_bit(1'b0, 30);
        drive_bit(1'b1, 2 * bit_clks());
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL glitch_valid: got %b expected 0", rx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL glitch_busy: got %b expected 0", busy); end
        n_checks++; if (ferr_cnt !== f0) begin n_fail++; $display("FAIL glitch_ferr: got %0d expected %0d", ferr_cnt, f0); end
    endtask

    // Stop held low for three bit times: one framing pulse, no word, busy until line high.
    task automatic test_framing();
        int f0 = ferr_cnt;
        divisor = 16'd8;
        send_frame(8'hA3, 1'b0, 3, 1'b0);
        rxd = 1'b0;
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL framing_busy_hold: got %b expected 1", busy); end
        n_checks++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL framing_pulses: got %0d expected %0d", ferr_cnt, f0 + 1); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL framing_no_push: got %b expected 0", rx_valid); end
        drive_bit(1'b1, bit_clks());
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL framing_busy_release: got %b expected 0", busy); end
        n_checks++; if (ferr_cnt !== f0 + 1) begin n_fail++; $display("FAIL framing_pulses_after: got %0d expected %0d", ferr_cnt, f0 + 1); end
    endtask

    // Five frames into a four-deep FIFO: full, overrun, oldest four kept.
    task automatic test_overrun();
        divisor = 16'd2;
        for (int i = 1; i <= 5; i++) begin
            send_frame(8'(i), 1'b1, 1, 1'b0);
            drive_bit(1'b1, bit_clks());
        end
        n_checks++; if (fifo_full !== 1'b1) begin n_fail++; $display("FAIL ovr_full: got %b expected 1", fifo_full); end
        n_checks++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_flag: got %b expected 1", overrun); end
        for (int i = 1; i <= 4; i++) begin
            n_checks++; if (rx_data !== 8'(i)) begin n_fail++; $display("FAIL ovr_pop_data: got %h expected %h", rx_data, 8'(i)); end
            pop();
            if (i == 1) begin
                n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b expected 0", overrun); end
                n_checks++; if (fifo_full !== 1'b0) begin n_fail++; $display("FAIL ovr_not_full: got %b expected 0", fifo_full); end
            end
        end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_drained: got %b expected 0", rx_valid); end
    endtask

    // Reset during bit 3 with two words queued, then a clean 0x7E.
    task automatic test_reset_midframe();
        logic [7:0] d = 8'h7E;
        divisor = 16'd4;
        send_frame(8'h11, 1'b1, 1, 1'b0);
        send_frame(8'h22, 1'b1, 1, 1'b0);
        drive_bit(1'b1, bit_clks());
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_queued: got %b expected 1", rx_valid); end
        drive_bit(1'b0, bit_clks());
        for (int i = 0; i < 3; i++) drive_bit(d[i], bit_clks());
        drive_bit(d[3], bit_clks()/2);
        #3 rst = 1'b1;
        #1;
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        rxd = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        drive_bit(1'b1, 2 * bit_clks());
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_no_partial: got %b expected 0", rx_valid); end
        send_frame(d, 1'b1, 1, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_new_valid: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== 8'h7E) begin n_fail++; $display("FAIL rstmid_new_data: got %h expected 7e", rx_data); end
        pop();
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_final: got %b expected 0", rx_valid); end
    endtask

    // Random words, divisors (including 0) and gaps, back-to-back frames allowed.
    task automatic test_random();
        logic [7:0] exp_q[$];
        bit         exp_ovr;
        logic [7:0] d;
        bit         flip;
        int         nfr;
        for (int it = 0; it < 5; it++) begin
            divisor = 16'($urandom_range(0, 5));
            nfr     = $urandom_range(1, 6);
            exp_ovr = 1'b0;
            for (int f = 0; f < nfr; f++) begin
                d = 8'($urandom);
`ifdef SPART_RX_PARITY_EN
                flip = ($urandom_range(0, 3) == 0);
`else
                flip = 1'b0;
`endif
                send_frame(d, 1'b1, 1, flip);
                if (!flip) begin
                    if (exp_q.size() < c_depth) exp_q.push_back(d);
                    else exp_ovr = 1'b1;
                end
                if ($urandom_range(0, 1) == 1) drive_bit(1'b1, bit_clks());
            end
            drive_bit(1'b1, bit_clks());
            n_checks++; if (overrun !== exp_ovr) begin n_fail++; $display("FAIL rand_overrun it%0d: got %b expected %b", it, overrun, exp_ovr); end
            n_checks++; if (fifo_full !== (exp_q.size() == c_depth)) begin n_fail++; $display("FAIL rand_full it%0d: got %b expected %b", it, fifo_full, exp_q.size() == c_depth); end
            while (exp_q.size() > 0) begin
                n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL rand_valid it%0d: got %b expected 1", it, rx_valid); end
                n_checks++; if (rx_data !== exp_q[0]) begin n_fail++; $display("FAIL rand_data it%0d: got %h expected %h", it, rx_data, exp_q[0]); end
                pop();
                void'(exp_q.pop_front());
            end
            n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL rand_empty it%0d: got %b expected 0", it, rx_valid); end
            n_checks++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL rand_ovr_clear it%0d: got %b expected 0", it, overrun); end
        end
    endtask

`ifdef SPART_RX_PARITY_EN
    // Even parity: 0x07 with parity 1 accepted, with parity 0 rejected.
    task automatic test_parity();
        int p0 = perr_cnt;
        divisor = 16'd4;
        parity_odd = 1'b0;
        send_frame(8'h07, 1'b1, 1, 1'b0);
        repeat (4) @(negedge clk);
        n_checks++; if (rx_valid !== 1'b1) begin n_fail++; $display("FAIL par_ok_valid: got %b expected 1", rx_valid); end
        n_checks++; if (rx_data !== 8'h07) begin n_fail++; $display("FAIL par_ok_data: got %h expected 07", rx_data); end
        n_checks++; if (perr_cnt !== p0) begin n_fail++; $display("FAIL par_ok_perr: got %0d expected %0d", perr_cnt, p0); end
        pop();
        send_frame(8'h07, 1'b1, 1, 1'b1);
        repeat (4) @(negedge clk);
        n_checks++; if (perr_cnt !== p0 + 1) begin n_fail++; $display("FAIL par_bad_perr: got %0d expected %0d", perr_cnt, p0 + 1); end
        n_checks++; if (rx_valid !== 1'b0) begin n_fail++; $display("FAIL par_bad_push: got %b expected 0", rx_valid); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_framing();
        test_overrun();
        test_reset_midframe();
        test_random();
`ifdef SPART_RX_PARITY_EN
        test_parity();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
